rps_round_ctrl: RTL and testbench

RPS_ROUND_CTRL -- requirements
Module: rps_round_ctrl

---
 rtl/rps_round_ctrl.sv | 95 +++++++++
 tb/tb_rps_round_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: rock-paper-scissors round sequencer with round timer control, scoring and match end
module rps_round_ctrl #(
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  input  logic       time_up,
  output logic       timer_reset,
  output logic       timer_in,
  output logic       round_active,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       match_over
);
  typedef enum logic [2:0] {IDLE, ARM, LAUNCH, PLAY, JUDGE, HOLD, OVER} state_t;
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0] WS = 4'(WIN_SCORE);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  state_t state;
  logic [1:0] m1, m2, res, judged;
  logic g1, g2, t1, t2, beats1, beats2;
  logic [CW-1:0] cnt;
  // move acceptance this cycle and the verdict from the latched moves
  always_comb begin
    t1 = state == PLAY && p1_valid && p1_move != 2'b11 && !g1;
    t2 = state == PLAY && p2_valid && p2_move != 2'b11 && !g2;
    beats1 = (m1 == 2'd1 && m2 == 2'd0) || (m1 == 2'd2 && m2 == 2'd1) || (m1 == 2'd0 && m2 == 2'd2);
    beats2 = (m2 == 2'd1 && m1 == 2'd0) || (m2 == 2'd2 && m1 == 2'd1) || (m2 == 2'd0 && m1 == 2'd2);
    judged = g1 && g2 ? (beats1 ? 2'b01 : beats2 ? 2'b10 : 2'b11) : g1 ? 2'b01 : g2 ? 2'b10 : 2'b11;
  end
  // round sequencing, move latching, scoring and hold timing
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      p1_score <= '0;
      p2_score <= '0;
      g1       <= 1'b0;
      g2       <= 1'b0;
      m1       <= '0;
      m2       <= '0;
      cnt      <= '0;
      res      <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= ARM;
        ARM: begin
          g1    <= 1'b0;
          g2    <= 1'b0;
          m1    <= '0;
          m2    <= '0;
          state <= LAUNCH;
        end
        LAUNCH: state <= PLAY;
        PLAY: begin
          if (t1) {g1, m1} <= {1'b1, p1_move};
          if (t2) {g2, m2} <= {1'b1, p2_move};
          if (((g1 || t1) && (g2 || t2)) || time_up) state <= JUDGE;
        end
        JUDGE: begin
          res <= judged;
          cnt <= '0;
          if (judged == 2'b01 && p1_score < WS) p1_score <= p1_score + 4'd1;
          if (judged == 2'b10 && p2_score < WS) p2_score <= p2_score + 4'd1;
          state <= HOLD;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) state <= (p1_score == WS || p2_score == WS) ? OVER : IDLE;
          else cnt <= cnt + 1'b1;
        end
        OVER: begin
          if (start) begin
            p1_score <= '0;
            p2_score <= '0;
            state    <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign timer_reset  = reset || state == ARM;
  assign timer_in     = state == LAUNCH || state == PLAY;
  assign round_active = state == PLAY;
  assign result_valid = state == HOLD;
  assign match_over   = state == OVER;
  assign result       = (state == HOLD || state == OVER) ? res : 2'b00;
endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb_rps_round_ctrl: directed self-checking bench for the round controller
module tb_rps_round_ctrl;
  logic clk = 1'b0;
  logic reset, start, p1_valid, p2_valid, time_up;
  logic [1:0] p1_move, p2_move, result;
  logic timer_reset, timer_in, round_active, result_valid, match_over;
  logic [3:0] p1_score, p2_score;
  int checks = 0;
  int errors = 0;

  rps_round_ctrl #(.WIN_SCORE(3), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid), .p2_move(p2_move), .p2_valid(p2_valid),
    .time_up(time_up), .timer_reset(timer_reset), .timer_in(timer_in),
    .round_active(round_active), .result(result), .result_valid(result_valid),
    .p1_score(p1_score), .p2_score(p2_score), .match_over(match_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic moves(input logic v1, input logic [1:0] a, input logic v2, input logic [1:0] b);
    p1_valid = v1;
    p1_move  = a;
    p2_valid = v2;
    p2_move  = b;
  endtask

  task automatic begin_round;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic end_hold;
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    time_up = 1'b0;
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    tick();
    check("rst_timer_reset", timer_reset, 1);
    check("rst_active", round_active, 0);
    check("rst_result", {result_valid, result}, 0);
    check("rst_scores", {p1_score, p2_score}, 0);
    check("rst_over", match_over, 0);
    reset = 1'b0;
    #1;
    check("idle_timer_reset", timer_reset, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_timer_reset", timer_reset, 1);
    check("arm_timer_in", timer_in, 0);
    tick();
    check("launch_timer", {timer_reset, timer_in, round_active}, 3'b010);
    tick();
    check("play_active", {timer_in, round_active}, 2'b11);
    moves(1'b1, 2'd1, 1'b1, 2'd0);
    tick();
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    check("judge_state", {round_active, result_valid, result}, 0);
    tick();
    check("r1_result", {result_valid, result}, 3'b101);
    check("r1_scores", {p1_score, p2_score}, 8'h10);
    repeat (7) tick();
    check("r1_hold_last", result_valid, 1);
    tick();
    check("r1_idle", {result_valid, result, round_active}, 0);

    begin_round();
    moves(1'b1, 2'd3, 1'b0, 2'd0);
    tick();
    check("r2_invalid_ignored", round_active, 1);
    moves(1'b1, 2'd2, 1'b0, 2'd0);
    tick();
    check("r2_one_latched", round_active, 1);
    moves(1'b1, 2'd0, 1'b1, 2'd2);
    tick();
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    check("r2_draw", {result_valid, result}, 3'b111);
    check("r2_scores", {p1_score, p2_score}, 8'h10);
    end_hold();

    begin_round();
    moves(1'b0, 2'd0, 1'b1, 2'd1);
    tick();
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    check("r3_wait", round_active, 1);
    time_up = 1'b1;
    tick();
    time_up = 1'b0;
    tick();
    check("r3_forfeit", {result_valid, result}, 3'b110);
    check("r3_scores", {p1_score, p2_score}, 8'h11);
    end_hold();

    begin_round();
    time_up = 1'b1;
    tick();
    time_up = 1'b0;
    tick();
    check("r4_nomove_draw", {result_valid, result}, 3'b111);
    check("r4_scores", {p1_score, p2_score}, 8'h11);
    end_hold();

    begin_round();
    moves(1'b1, 2'd1, 1'b1, 2'd0);
    time_up = 1'b1;
    tick();
    time_up = 1'b0;
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    check("r5_moves_over_timeup", {result_valid, result}, 3'b101);
    check("r5_scores", {p1_score, p2_score}, 8'h21);
    end_hold();
    check("r5_not_over", match_over, 0);

    begin_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r6_start_ignored", {round_active, timer_reset}, 2'b10);
    moves(1'b1, 2'd0, 1'b1, 2'd2);
    tick();
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    check("r6_result", {result_valid, result}, 3'b101);
    check("r6_scores", {p1_score, p2_score}, 8'h31);
    end_hold();
    check("over_flag", match_over, 1);
    check("over_result_frozen", {result_valid, result}, 3'b001);
    tick();
    check("over_scores_frozen", {p1_score, p2_score}, 8'h31);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_scores", {p1_score, p2_score}, 0);
    check("restart_arm", {match_over, timer_reset}, 2'b01);
    tick();
    tick();
    moves(1'b1, 2'd1, 1'b1, 2'd2);
    tick();
    moves(1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    check("r7_p2_wins", {result_valid, result}, 3'b110);
    check("r7_scores", {p1_score, p2_score}, 8'h01);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midhold_reset_state", {result_valid, result, round_active}, 0);
    check("midhold_reset_scores", {p1_score, p2_score}, 0);
    check("midhold_timer_reset", timer_reset, 1);
    reset = 1'b0;
    tick();
    check("post_reset_idle", {timer_reset, timer_in, round_active, match_over}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
